// File: rtl/series_eval_engine_pkg.sv
// Shared types and the Taylor coefficient generator for the series evaluator.
// coeff() is evaluated at elaboration time to build the coefficient ROM.
package series_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCEPT  = 3'd1,
    COMPUTE = 3'd2,
    OUTPUT  = 3'd3,
    ERROR   = 3'd4
  } state_t;

  localparam int COEFF_W = 32;

  // round(2^frac_w / k!) with a 64-bit factorial so k up to ~20 stays exact.
  function automatic logic signed [COEFF_W-1:0] coeff(input int k, input int frac_w);
    logic [63:0] fact;
    logic [63:0] num;
    fact = 64'd1;
    for (int i = 2; i <= k; i++) fact = fact * 64'(i);
    num = 64'd1 << frac_w;
    return COEFF_W'((2 * num + fact) / (2 * fact));
  endfunction

endpackage

// File: rtl/series_mac.sv
// One combinational Horner step: acc_next = (acc*x >>> FRAC_W) + c.
// out_of_range flags a sum that does not fit back into ACC_W bits.
module series_mac #(
  parameter int ACC_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [ACC_W-1:0] x,
  input  logic signed [ACC_W-1:0] c,
  output logic signed [ACC_W-1:0] acc_next,
  output logic                    out_of_range
);

  logic signed [2*ACC_W-1:0] prod;
  logic signed [2*ACC_W-1:0] shifted;
  logic signed [2*ACC_W:0]   sum;

  always_comb begin
    prod     = (2*ACC_W)'(acc) * (2*ACC_W)'(x);
    shifted  = prod >>> FRAC_W;
    sum      = (2*ACC_W+1)'(shifted) + (2*ACC_W+1)'(c);
    acc_next = sum[ACC_W-1:0];
    // fits in ACC_W only if every bit above the ACC_W sign bit repeats it
    out_of_range = (sum[2*ACC_W:ACC_W-1] != {(ACC_W+2){sum[ACC_W-1]}});
  end

endmodule

// File: rtl/series_eval_engine.sv
// Iterative Horner evaluator of Y = sum C[k]*X^k, one MAC step per clock,
// with a ready/valid stream interface and saturate or wrap result mode.
module series_eval_engine
  import series_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int FRAC_W    = 4,
  parameter int MAX_TERMS = 8,
  parameter int GUARD_W   = 8,
  parameter int SAT_MODE  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [$clog2(MAX_TERMS+1)-1:0] n,
  input  logic                           x_valid,
  input  logic [DATA_W-1:0]              X,
  output logic                           ready,
  output logic                           valid,
  output logic [DATA_W-1:0]              Y,
  output logic                           overflow,
  output logic                           error
);

  localparam int ACC_W = DATA_W + GUARD_W;
  localparam int N_W   = $clog2(MAX_TERMS + 1);

  state_t state, state_nx;

  logic [N_W-1:0]          n_reg;
  logic [N_W-1:0]          k;
  logic [DATA_W-1:0]       x_reg;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_step;
  logic signed [ACC_W-1:0] x_ext;
  logic                    step_ovf;
  logic                    ovf_sticky;
  logic                    n_legal;
  logic                    accept;
  logic                    fits;
  logic [DATA_W-1:0]       y_res;

  // ROM spans the full index range so n-1 and k never index past the end
  logic signed [ACC_W-1:0] c_tab [2**N_W];

  for (genvar g = 0; g < 2**N_W; g++) begin : g_coeff
    assign c_tab[g] = ACC_W'(coeff(g, FRAC_W));
  end

  assign n_legal = (n != '0) && (n <= N_W'(MAX_TERMS));
  assign accept  = (state == ACCEPT) && x_valid && !start;
  assign x_ext   = {{GUARD_W{x_reg[DATA_W-1]}}, x_reg};

  series_mac #(
    .ACC_W  (ACC_W),
    .FRAC_W (FRAC_W)
  ) u_mac (
    .acc          (acc),
    .x            (x_ext),
    .c            (c_tab[k]),
    .acc_next     (acc_step),
    .out_of_range (step_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    error    = 1'b0;
    case (state)
      ACCEPT: begin
        ready = 1'b1;
        if (x_valid) state_nx = (n_reg == N_W'(1)) ? OUTPUT : COMPUTE;
      end
      COMPUTE: if (k == '0) state_nx = OUTPUT;
      OUTPUT:  state_nx = ACCEPT;
      ERROR:   error = 1'b1;
      default: ;
    endcase
    // start overrides whatever the current state wanted, including an accept
    if (start) state_nx = n_legal ? ACCEPT : ERROR;
  end

  always_comb begin
    fits = (acc[ACC_W-1:DATA_W-1] == {(GUARD_W+1){acc[ACC_W-1]}});
    if (fits || SAT_MODE == 0) y_res = acc[DATA_W-1:0];
    else if (acc[ACC_W-1])     y_res = {1'b1, {(DATA_W-1){1'b0}}};
    else                       y_res = {1'b0, {(DATA_W-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_reg      <= '0;
      k          <= '0;
      x_reg      <= '0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
      valid      <= 1'b0;
      Y          <= '0;
      overflow   <= 1'b0;
    end else begin
      valid    <= 1'b0;
      overflow <= 1'b0;
      if (start) begin
        n_reg <= n;
      end else if (accept) begin
        x_reg      <= X;
        acc        <= c_tab[n_reg - 1'b1];
        k          <= n_reg - 2'd2;
        ovf_sticky <= 1'b0;
      end else if (state == COMPUTE) begin
        acc        <= acc_step;
        k          <= k - 1'b1;
        ovf_sticky <= ovf_sticky | step_ovf;
      end else if (state == OUTPUT) begin
        valid    <= 1'b1;
        Y        <= y_res;
        overflow <= ovf_sticky | ~fits;
      end
    end
  end

endmodule

// File: tb/tb_series_eval_engine.sv
// Bench for series_eval_engine: directed vector table, corner sequences and
// randomized streams checked against an arithmetic reference model.
module tb_series_eval_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] n_in = '0;
  logic       x_valid = 1'b0;
  logic [7:0] x_in = '0;
  logic       ready, valid, overflow, error;
  logic [7:0] y_out;
  logic       ready_w, valid_w, overflow_w, error_w;
  logic [7:0] y_w;

  int total = 0;
  int bad   = 0;

  int coef [8] = '{16, 16, 8, 3, 1, 0, 0, 0};

  always #5 clk = ~clk;

  series_eval_engine #(.SAT_MODE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n_in), .x_valid(x_valid), .X(x_in),
    .ready(ready), .valid(valid), .Y(y_out), .overflow(overflow), .error(error)
  );

  series_eval_engine #(.SAT_MODE(0)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .n(n_in), .x_valid(x_valid), .X(x_in),
    .ready(ready_w), .valid(valid_w), .Y(y_w), .overflow(overflow_w), .error(error_w)
  );

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain integer Horner with 16-bit accumulator wrap and range tracking.
  function automatic void model(input int nn, input int xx, output int y, output bit ov,
                                output int yw);
    longint a, s;
    logic [63:0] sb;
    logic [15:0] t;
    logic [7:0] b;
    bit sticky;
    sticky = 0;
    a = coef[nn-1];
    for (int kk = nn - 2; kk >= 0; kk--) begin
      s = ((a * xx) >>> 4) + coef[kk];
      if (s > 32767 || s < -32768) sticky = 1;
      sb = s;
      t = sb[15:0];
      a = longint'($signed(t));
    end
    ov = sticky || a > 127 || a < -128;
    y  = (a > 127) ? 127 : (a < -128) ? -128 : int'(a);
    sb = a;
    b  = sb[7:0];
    yw = int'($signed(b));
  endfunction

  task automatic run_one(input int nn, input int xx, output int y, output bit ov,
                         output int yw, output bit ovw, output int lat);
    @(negedge clk); start = 1'b1; n_in = 4'(nn);
    @(negedge clk); start = 1'b0; x_in = 8'(xx); x_valid = 1'b1;
    @(posedge clk); #1; x_valid = 1'b0;
    lat = 0;
    while (!valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    y   = int'($signed(y_out));
    ov  = overflow;
    yw  = int'($signed(y_w));
    ovw = overflow_w;
  endtask

  typedef struct {
    int n; int x; int y; bit ovf; int yw; bit ovfw;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int y, yw, lat, last_y, got, sent;
    bit ov, ovw, saw_valid, will_acc;
    int ey, eyw;
    bit eov;
    int q [$];
    int ns [5] = '{2, 3, 4, 5, 7};

    vecs[0] = '{3,   16,   40, 0,   40, 0};
    vecs[1] = '{3,  -16,    8, 0,    8, 0};
    vecs[2] = '{3,  112,  127, 1,    8, 1};
    vecs[3] = '{1, -100,   16, 0,   16, 0};
    vecs[4] = '{2,   32,   48, 0,   48, 0};
    vecs[5] = '{2,   -8,    8, 0,    8, 0};
    vecs[6] = '{8,   16,   44, 0,   44, 0};
    vecs[7] = '{4, -128, -128, 1, -112, 1};
    vecs[8] = '{2,   -1,   15, 0,   15, 0};

    #1;
    check("rst_ready", ready, 0);
    check("rst_valid", valid, 0);
    check("rst_error", error, 0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) begin
      run_one(vecs[i].n, vecs[i].x, y, ov, yw, ovw, lat);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].n);
      check($sformatf("vec%0d_y", i), y, vecs[i].y);
      check($sformatf("vec%0d_ovf", i), ov, vecs[i].ovf);
      check($sformatf("vec%0d_y_wrap", i), yw, vecs[i].yw);
      check($sformatf("vec%0d_ovf_wrap", i), ovw, vecs[i].ovfw);
    end
    last_y = y;

    repeat (3) @(posedge clk);
    #1;
    check("hold_valid", valid, 0);
    check("hold_y", int'($signed(y_out)), last_y);
    check("hold_ovf", overflow, 0);

    // illegal term counts
    @(negedge clk); start = 1'b1; n_in = 4'd0;
    @(negedge clk); start = 1'b0;
    check("n0_error", error, 1);
    check("n0_ready", ready, 0);
    @(negedge clk); start = 1'b1; n_in = 4'd9;
    @(negedge clk); start = 1'b0; x_valid = 1'b1; x_in = 8'd16;
    check("n9_error", error, 1);
    check("n9_ready", ready, 0);
    saw_valid = 0;
    repeat (6) begin @(posedge clk); #1; if (valid) saw_valid = 1; end
    x_valid = 1'b0;
    check("error_no_valid", saw_valid, 0);
    @(negedge clk); start = 1'b1; n_in = 4'd2;
    @(negedge clk); start = 1'b0;
    check("recover_error", error, 0);
    check("recover_ready", ready, 1);

    // start and x_valid together: start wins, nothing is accepted
    @(negedge clk); start = 1'b1; n_in = 4'd3; x_valid = 1'b1; x_in = 8'd16;
    @(negedge clk); start = 1'b0; x_valid = 1'b0;
    check("start_wins_ready", ready, 1);
    saw_valid = 0;
    repeat (6) begin @(posedge clk); #1; if (valid) saw_valid = 1; end
    check("start_wins_no_valid", saw_valid, 0);

    // start aborts a computation in flight
    @(negedge clk); start = 1'b1; n_in = 4'd5;
    @(negedge clk); start = 1'b0; x_valid = 1'b1; x_in = 8'd16;
    @(negedge clk); x_valid = 1'b0;
    @(negedge clk);
    check("mid_compute_busy", ready, 0);
    start = 1'b1; n_in = 4'd3;
    @(negedge clk); start = 1'b0;
    check("abort_ready", ready, 1);
    saw_valid = 0;
    repeat (8) begin @(posedge clk); #1; if (valid) saw_valid = 1; end
    check("abort_no_valid", saw_valid, 0);
    run_one(3, 16, y, ov, yw, ovw, lat);
    check("after_abort_y", y, 40);

    // reset mid-compute discards the result
    @(negedge clk); start = 1'b1; n_in = 4'd7;
    @(negedge clk); start = 1'b0; x_valid = 1'b1; x_in = 8'd20;
    @(negedge clk); x_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    check("rst_mid_y", int'(y_out), 0);
    check("rst_mid_ready", ready, 0);
    check("rst_mid_valid", valid, 0);
    @(negedge clk); rst = 1'b0;
    saw_valid = 0;
    repeat (10) begin @(posedge clk); #1; if (valid) saw_valid = 1; end
    check("rst_mid_no_valid", saw_valid, 0);
    check("rst_mid_idle_ready", ready, 0);

    // randomized streams with x_valid jitter
    foreach (ns[j]) begin
      @(negedge clk); start = 1'b1; n_in = 4'(ns[j]);
      @(negedge clk); start = 1'b0;
      got = 0; sent = 0; q.delete();
      for (int cyc = 0; cyc < 3000 && got < 20; cyc++) begin
        if (!x_valid && sent < 20 && $urandom_range(0, 2) != 0) begin
          x_in = 8'($urandom_range(0, 255));
          x_valid = 1'b1;
        end
        will_acc = x_valid && ready;
        @(posedge clk); #1;
        if (will_acc) begin
          q.push_back(int'($signed(x_in)));
          sent++;
          x_valid = 1'b0;
        end
        if (valid) begin
          if (q.size() == 0) begin
            check($sformatf("rand_n%0d_spurious", ns[j]), 1, 0);
          end else begin
            model(ns[j], q.pop_front(), ey, eov, eyw);
            check($sformatf("rand_n%0d_y", ns[j]), int'($signed(y_out)), ey);
            check($sformatf("rand_n%0d_ovf", ns[j]), overflow, eov);
            check($sformatf("rand_n%0d_y_wrap", ns[j]), int'($signed(y_w)), eyw);
          end
          got++;
        end
        @(negedge clk);
      end
      x_valid = 1'b0;
      check($sformatf("rand_n%0d_count", ns[j]), got, 20);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
